id_stage_pipe: RTL and testbench

//  Parametrised, registered instruction-decode stage sitting between IF and EX.

---
 rtl/id_stage_pipe_if.sv | 31 +++
 rtl/id_stage_pipe.sv | 104 ++++++++++
 tb/tb_id_stage_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// IF -> ID -> EX handshake and decoded-field bundle for id_stage_pipe.
// The slave modport is the decode stage's view; master is the view of the
// environment that feeds instructions and consumes decoded fields.
interface id_stage_pipe_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned REG_W   = 2
);
    localparam int unsigned IMM_W = INSTR_W - OPC_W - 3 * REG_W;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic [IMM_W-1:0]   imm;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, opcode, rs1, rs2, rd, imm
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, opcode, rs1, rs2, rd, imm
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage between IF and EX.
// Splits an instruction into opcode/rs1/rs2/rd/imm, holds the result in an
// ID/EX register with valid/ready on both sides, supports a synchronous
// flush and counts instructions handed to EX.
// Optional feature macro: ID_HAZARD_STALL_EN enables a RAW interlock against
// the destination register of the instruction currently in EX.
// IMM_W = INSTR_W - OPC_W - 3*REG_W must be at least 1.
module id_stage_pipe #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned REG_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    id_stage_pipe_if.slave      bus,
    input  logic [REG_W-1:0]    ex_rd,
    input  logic                ex_wr_en,
    output logic                hazard_stall,
    output logic [CNT_W-1:0]    dec_count
);

    localparam int unsigned IMM_W   = INSTR_W - OPC_W - 3 * REG_W;
    localparam int unsigned OPC_LSB = INSTR_W - OPC_W;
    localparam int unsigned RS1_LSB = OPC_LSB - REG_W;
    localparam int unsigned RS2_LSB = RS1_LSB - REG_W;
    localparam int unsigned RD_LSB  = RS2_LSB - REG_W;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
    } fields_t;

    fields_t dec_c;
    fields_t fields_q;
    logic    out_valid_q;
    logic    load_c;
    logic    xfer_c;

    // Field extraction from the instruction currently offered by IF
    always_comb begin
        dec_c        = '0;
        dec_c.opcode = bus.instr[OPC_LSB +: OPC_W];
        dec_c.rs1    = bus.instr[RS1_LSB +: REG_W];
        dec_c.rs2    = bus.instr[RS2_LSB +: REG_W];
        dec_c.rd     = bus.instr[RD_LSB +: REG_W];
        dec_c.imm    = bus.instr[IMM_W-1:0];
    end

`ifdef ID_HAZARD_STALL_EN
    // RAW interlock: incoming source matches the register EX is about to write
    always_comb begin
        hazard_stall = !rst & bus.in_valid & ex_wr_en &
                       ((dec_c.rs1 == ex_rd) | (dec_c.rs2 == ex_rd));
    end
`else
    // Interlock disabled; EX destination inputs are intentionally ignored
    logic unused_ex_inputs;
    assign unused_ex_inputs = ^{ex_rd, ex_wr_en};
    assign hazard_stall     = 1'b0;
`endif

    // Accept when the register is empty or being drained this cycle; a flush
    // still shows ready but suppresses the load, so IF must re-present
    assign bus.in_ready = !rst & !hazard_stall & (!out_valid_q | bus.out_ready);
    assign load_c       = bus.in_valid & bus.in_ready & !flush;
    assign xfer_c       = out_valid_q & bus.out_ready & !flush;

    // ID/EX pipeline register: flush beats load, load beats drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            fields_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load_c) begin
            out_valid_q <= 1'b1;
            fields_q    <= dec_c;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Retired-decode counter, wraps silently at 2**CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_count <= '0;
        end else if (xfer_c) begin
            dec_count <= dec_count + CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = fields_q.opcode;
    assign bus.rs1       = fields_q.rs1;
    assign bus.rs2       = fields_q.rs2;
    assign bus.rd        = fields_q.rd;
    assign bus.imm       = fields_q.imm;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: the driver pushes the index of each
// accepted vector, a negedge monitor compares the held/transferred fields
// against hand-decoded expectations and tracks the expected decode count.
module tb_id_stage_pipe;

    typedef struct packed {
        logic [15:0] instr;
        logic [3:0]  opc;
        logic [1:0]  rs1;
        logic [1:0]  rs2;
        logic [1:0]  rd;
        logic [5:0]  imm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  ex_rd = 2'd0;
    logic        ex_wr_en = 1'b0;
    logic        hazard_stall;
    logic [15:0] dec_count;
    logic        hazard_stall2;
    logic [3:0]  dec_count2;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          exp_q[$];
    logic [15:0] exp_cnt = 16'd0;
    vec_t        vecs[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_stage_pipe_if #(.INSTR_W(16), .OPC_W(4), .REG_W(2)) bus();
    id_stage_pipe_if #(.INSTR_W(32), .OPC_W(6), .REG_W(5)) bus2();

    id_stage_pipe #(.INSTR_W(16), .OPC_W(4), .REG_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .hazard_stall(hazard_stall), .dec_count(dec_count)
    );

    id_stage_pipe #(.INSTR_W(32), .OPC_W(6), .REG_W(5), .CNT_W(4)) dut32 (
        .clk(clk), .rst(rst), .flush(1'b0), .bus(bus2),
        .ex_rd(5'd0), .ex_wr_en(1'b0),
        .hazard_stall(hazard_stall2), .dec_count(dec_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector and hold it until accepted (bounded)
    task automatic send(input int idx);
        bit ok;
        ok = 1'b0;
        bus.instr    = vecs[idx].instr;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                exp_q.push_back(idx);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: vector %0d never accepted", idx);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compare whatever the stage presents against the queue head
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_cnt = 16'd0;
            end else begin
                check("dec_count", 32'(dec_count), 32'(exp_cnt));
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: out_valid=1 with nothing expected (t=%0t)", $time);
                    end else begin
                        idx = exp_q[0];
                        check("opcode", 32'(bus.opcode), 32'(vecs[idx].opc));
                        check("rs1", 32'(bus.rs1), 32'(vecs[idx].rs1));
                        check("rs2", 32'(bus.rs2), 32'(vecs[idx].rs2));
                        check("rd", 32'(bus.rd), 32'(vecs[idx].rd));
                        check("imm", 32'(bus.imm), 32'(vecs[idx].imm));
                        if (flush) begin
                            void'(exp_q.pop_front());
                        end else if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            exp_cnt = exp_cnt + 16'd1;
                        end else begin
                            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vecs[0]  = '{16'b0011_01_10_11_101010, 4'h3, 2'd1, 2'd2, 2'd3, 6'h2A};
        vecs[1]  = '{16'b1111_11_11_11_111111, 4'hF, 2'd3, 2'd3, 2'd3, 6'h3F};
        vecs[2]  = '{16'b0000_00_00_00_000000, 4'h0, 2'd0, 2'd0, 2'd0, 6'h00};
        vecs[3]  = '{16'b1010_10_01_00_010101, 4'hA, 2'd2, 2'd1, 2'd0, 6'h15};
        vecs[4]  = '{16'b0101_01_10_10_101010, 4'h5, 2'd1, 2'd2, 2'd2, 6'h2A};
        vecs[5]  = '{16'b1000_00_11_01_000001, 4'h8, 2'd0, 2'd3, 2'd1, 6'h01};
        vecs[6]  = '{16'b0001_11_00_10_100000, 4'h1, 2'd3, 2'd0, 2'd2, 6'h20};
        vecs[7]  = '{16'b1100_10_10_01_011110, 4'hC, 2'd2, 2'd2, 2'd1, 6'h1E};
        vecs[8]  = '{16'b0110_01_00_11_110011, 4'h6, 2'd1, 2'd0, 2'd3, 6'h33};
        vecs[9]  = '{16'b1001_00_01_10_001100, 4'h9, 2'd0, 2'd1, 2'd2, 6'h0C};
        vecs[10] = '{16'b0111_11_01_00_111000, 4'h7, 2'd3, 2'd1, 2'd0, 6'h38};
        vecs[11] = '{16'b1110_00_10_01_000111, 4'hE, 2'd0, 2'd2, 2'd1, 6'h07};
        vecs[12] = '{16'b0100_01_10_00_000011, 4'h4, 2'd1, 2'd2, 2'd0, 6'h03};

        // T1: reset with a request pending
        rst = 1'b1;
        ex_rd = 2'd3;
        ex_wr_en = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr = 16'hFFFF;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b1;
        bus2.instr = '1;
        bus2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_rs1", 32'(bus.rs1), 32'd0);
        check("rst_rs2", 32'(bus.rs2), 32'd0);
        check("rst_rd", 32'(bus.rd), 32'd0);
        check("rst_imm", 32'(bus.imm), 32'd0);
        check("rst_dec_count", 32'(dec_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_hazard", 32'(hazard_stall), 32'd0);
        check("rst_in_ready32", 32'(bus2.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        ex_wr_en = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        step();

        // T2: single decode, latency 1
        send(0);
        @(negedge clk);
        check("t2_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        @(negedge clk);
        check("t2_dec_count", 32'(dec_count), 32'd1);
        check("t2_drained", 32'(bus.out_valid), 32'd0);
        step();

        // T3: backpressure for three cycles with a new instr offered
        bus.out_ready = 1'b0;
        send(1);
        fork
            send(2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t3_in_ready", 32'(bus.in_ready), 32'd0);
                    check("t3_out_valid", 32'(bus.out_valid), 32'd1);
                end
                step();
                bus.out_ready = 1'b1;
            end
        join

        // T4: ten back-to-back instrs, one accept per cycle
        t0 = cyc;
        for (int i = 3; i <= 11; i++) send(i);
        send(0);
        check("t4_throughput", 32'(cyc - t0), 32'd10);
        step();
        @(negedge clk);
        check("t4_dec_count", 32'(dec_count), 32'd13);
        check("t4_drained", 32'(bus.out_valid), 32'd0);
        step();

        // T5: flush a held instr while another is offered and EX is ready
        bus.out_ready = 1'b0;
        send(5);
        bus.instr = vecs[6].instr;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_dec_count", 32'(dec_count), 32'd13);
        step();
        send(6);
        step();
        @(negedge clk);
        check("t5_reoffer_count", 32'(dec_count), 32'd14);
        step();

        // T6: incoming rs2 matches the EX destination
        bus.out_ready = 1'b0;
        send(7);
        ex_rd = 2'd2;
        ex_wr_en = 1'b1;
        bus.out_ready = 1'b1;
        fork
            send(12);
            begin
`ifdef ID_HAZARD_STALL_EN
                @(negedge clk);
                check("t6_hazard", 32'(hazard_stall), 32'd1);
                check("t6_in_ready", 32'(bus.in_ready), 32'd0);
                @(negedge clk);
                check("t6_bubble", 32'(bus.out_valid), 32'd0);
                check("t6_hazard_held", 32'(hazard_stall), 32'd1);
`else
                @(negedge clk);
                check("t6_hazard", 32'(hazard_stall), 32'd0);
                check("t6_in_ready", 32'(bus.in_ready), 32'd1);
`endif
                step();
                ex_wr_en = 1'b0;
            end
        join
        step();
        @(negedge clk);
        check("t6_dec_count", 32'(dec_count), 32'd16);
        check("t6_drained", 32'(bus.out_valid), 32'd0);
        step();

        // Wide configuration: field placement and 4-bit counter wrap
        bus2.instr = 32'b000011_00001_00010_00011_00000101010;
        bus2.in_valid = 1'b1;
        step();
        @(negedge clk);
        check("w_out_valid", 32'(bus2.out_valid), 32'd1);
        check("w_opcode", 32'(bus2.opcode), 32'd3);
        check("w_rs1", 32'(bus2.rs1), 32'd1);
        check("w_rs2", 32'(bus2.rs2), 32'd2);
        check("w_rd", 32'(bus2.rd), 32'd3);
        check("w_imm", 32'(bus2.imm), 32'h2A);
        check("w_count0", 32'(dec_count2), 32'd0);
        repeat (16) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        step();
        @(negedge clk);
        check("w_count_wrap", 32'(dec_count2), 32'd1);
        check("w_drained", 32'(bus2.out_valid), 32'd0);
        check("w_hazard", 32'(hazard_stall2), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
